data_mem_ctrl: RTL and testbench

- Parametrised, byte-addressable data memory for the core's load/store path, with a request/response handshake and configurable access latency.
- Supports byte, halfword and word stores and loads, with sign or zero extension on loads.
- Detects bad-size, misaligned and out-of-range accesses and reports them as faults; a faulting access never modifies memory.
- Memory byte order is big-endian: the lowest address holds the most significant byte of the accessed quantity.

---
 rtl/data_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressable big-endian data memory with request/response handshake
// Fixed access latency; bad-size, misaligned and out-of-range accesses fault without touching memory.
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 2048,
  parameter int LATENCY     = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_err_code
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          l_we;
  logic [1:0]    l_size;
  logic          l_unsigned;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;

  logic [7:0]    mem [DEPTH_BYTES];

  logic [2:0]    nbytes;
  logic [32:0]   end_addr;
  logic [1:0]    fault_code;
  logic [AW-1:0] idx [4];
  logic [7:0]    wbyte [4];
  logic [31:0]   load_val;
  logic          commit;
  logic          do_write;

  // Gated by reset so the requester never sees ready while reset is held.
  assign req_ready = (state == IDLE) && !reset;
  assign commit    = (state == WAIT) && (cnt == '0);
  assign do_write  = commit && !reset && l_we && (fault_code == 2'b00);

  always_comb begin
    case (l_size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    end_addr = {1'b0, l_addr} + {30'd0, nbytes};
    if (l_size == 2'd3)
      fault_code = 2'b11;
    else if ((ALIGN_CHECK != 0) &&
             (((l_size == 2'd1) && l_addr[0]) || ((l_size == 2'd2) && (l_addr[1:0] != 2'b00))))
      fault_code = 2'b01;
    else if (end_addr > 33'(DEPTH_BYTES))
      fault_code = 2'b10;
    else
      fault_code = 2'b00;
  end

  // Big-endian: byte at the lowest address is the most significant of the quantity.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k]   = l_addr[AW-1:0] + AW'(k);
      wbyte[k] = 8'h00;
    end
    load_val = 32'd0;
    case (l_size)
      2'd0: begin
        wbyte[0] = l_wdata[7:0];
        load_val = {{24{~l_unsigned & mem[idx[0]][7]}}, mem[idx[0]]};
      end
      2'd1: begin
        wbyte[0] = l_wdata[15:8];
        wbyte[1] = l_wdata[7:0];
        load_val = {{16{~l_unsigned & mem[idx[0]][7]}}, mem[idx[0]], mem[idx[1]]};
      end
      default: begin
        wbyte[0] = l_wdata[31:24];
        wbyte[1] = l_wdata[23:16];
        wbyte[2] = l_wdata[15:8];
        wbyte[3] = l_wdata[7:0];
        load_val = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) mem[idx[k]] <= wbyte[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
      resp_err_code <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_we       <= req_we;
            l_size     <= req_size;
            l_unsigned <= req_unsigned;
            l_addr     <= req_addr;
            l_wdata    <= req_wdata;
            cnt        <= CW'(LATENCY - 1);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state         <= RESP;
            resp_valid    <= 1'b1;
            resp_err      <= (fault_code != 2'b00);
            resp_err_code <= fault_code;
            resp_rdata    <= (l_we || (fault_code != 2'b00)) ? 32'd0 : load_val;
          end
        end
        RESP: begin
          state         <= IDLE;
          resp_valid    <= 1'b0;
          resp_rdata    <= 32'd0;
          resp_err      <= 1'b0;
          resp_err_code <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
// Three instances cover LATENCY 1/3/4 and both alignment modes.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we [3];
  logic [1:0]  req_size [3];
  logic        req_unsigned [3];
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err [3];
  logic [1:0]  resp_err_code [3];

  data_mem_ctrl #(.DEPTH_BYTES(2048), .LATENCY(1), .ALIGN_CHECK(1)) u0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .resp_err_code(resp_err_code[0]));

  data_mem_ctrl #(.DEPTH_BYTES(2048), .LATENCY(3), .ALIGN_CHECK(1)) u1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .resp_err_code(resp_err_code[1]));

  data_mem_ctrl #(.DEPTH_BYTES(2048), .LATENCY(4), .ALIGN_CHECK(0)) u2 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .resp_err_code(resp_err_code[2]));

  int errors = 0;
  int checks = 0;
  bit [7:0] ref_mem [3][2048];

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp_rd;
    bit [1:0]  exp_code;
  } vec_t;
  vec_t tbl [$];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  function automatic bit align_of(input int d);
    return (d != 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: fault rules in wide arithmetic, data as a shifted byte stream.
  task automatic model_ref(input int d, input bit we, input bit [1:0] size, input bit uns,
                           input bit [31:0] addr, input bit [31:0] wdata,
                           output bit [31:0] rd, output bit [1:0] code);
    int n;
    bit [31:0] v;
    n  = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    rd = 32'd0;
    if (size == 3) code = 2'b11;
    else if (align_of(d) && ((addr % n) != 0)) code = 2'b01;
    else if (longint'(addr) + longint'(n) > 64'd2048) code = 2'b10;
    else code = 2'b00;
    if (code == 2'b00) begin
      if (we) begin
        for (int k = 0; k < n; k++)
          ref_mem[d][int'(addr) + k] = 8'(wdata >> (8 * (n - 1 - k)));
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++)
          v = (v << 8) | 32'(ref_mem[d][int'(addr) + k]);
        if (!uns && (n < 4) && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
      end
    end
  endtask

  task automatic access(input int d, input bit we, input bit [1:0] size, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wdata,
                        output bit [31:0] rd, output bit err, output bit [1:0] code,
                        output int lat);
    int t;
    t = 0;
    while (!req_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd   = resp_rdata[d];
    err  = resp_err[d];
    code = resp_err_code[d];
    @(negedge clk);
  endtask

  task automatic run_check(input int d, input string name, input bit we, input bit [1:0] size,
                           input bit uns, input bit [31:0] addr, input bit [31:0] wdata,
                           input bit [31:0] exp_rd, input bit [1:0] exp_code);
    bit [31:0] rd;
    bit err;
    bit [1:0] code;
    int lat;
    access(d, we, size, uns, addr, wdata, rd, err, code, lat);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, 32'(err), 32'(exp_code != 2'b00));
    chk({name, "_code"}, 32'(code), 32'(exp_code));
    chk({name, "_lat"}, lat, lat_of(d));
  endtask

  task automatic random_phase(input int d, input int nops);
    bit [31:0] rd, wd, addr;
    bit [1:0] code, size;
    bit we, uns;
    for (int a = 32'h400; a < 32'h800; a += 4) begin
      wd = $urandom;
      model_ref(d, 1'b1, 2'd2, 1'b0, a, wd, rd, code);
      run_check(d, $sformatf("init%0d_%h", d, a), 1'b1, 2'd2, 1'b0, a, wd, rd, code);
    end
    for (int i = 0; i < nops; i++) begin
      we   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'h400 + $urandom_range(0, 32'h41F);
      model_ref(d, we, size, uns, addr, wd, rd, code);
      run_check(d, $sformatf("rnd%0d_%0d", d, i), we, size, uns, addr, wd, rd, code);
    end
  endtask

  initial begin
    int t;
    bit seen;
    for (int d = 0; d < 3; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_ready", d), 32'(req_ready[d]), 32'd0);
      chk($sformatf("rst%0d_valid", d), 32'(resp_valid[d]), 32'd0);
      chk($sformatf("rst%0d_rdata", d), resp_rdata[d], 32'd0);
      chk($sformatf("rst%0d_err", d), 32'(resp_err[d]), 32'd0);
      chk($sformatf("rst%0d_code", d), 32'(resp_err_code[d]), 32'd0);
    end
    for (int d = 0; d < 3; d++) reset[d] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("rel%0d_ready", d), 32'(req_ready[d]), 32'd1);
    @(negedge clk);

    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h010, 32'h11223344, 32'h00000000, 2'b00});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h010, 32'h0,        32'h00000011, 2'b00});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h013, 32'h0,        32'h00000044, 2'b00});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'h11223344, 2'b00});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h012, 32'h0,        32'h00003344, 2'b00});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h020, 32'h12345680, 32'h00000000, 2'b00});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h020, 32'h0,        32'hFFFFFF80, 2'b00});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h020, 32'h0,        32'h00000080, 2'b00});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h022, 32'hAAAABEEF, 32'h00000000, 2'b00});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h022, 32'h0,        32'hFFFFBEEF, 2'b00});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h022, 32'h0,        32'h0000BEEF, 2'b00});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFEF00D, 32'h00000000, 2'b00});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h102, 32'h55667788, 32'h00000000, 2'b01});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hCAFEF00D, 2'b00});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h7FC, 32'h01020384, 32'h00000000, 2'b00});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h7FC, 32'h0,        32'h01020384, 2'b00});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h7FF, 32'h0,        32'hFFFFFF84, 2'b00});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h800, 32'hFFFFFFFF, 32'h00000000, 2'b10});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h800, 32'h0,        32'h00000000, 2'b10});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,   32'h00000000, 2'b10});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h103, 32'h0,        32'h00000000, 2'b11});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h801, 32'h0,        32'h00000000, 2'b11});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h101, 32'h0,        32'h00000000, 2'b01});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h7FF, 32'h0,        32'h00000000, 2'b01});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hCAFEF00D, 2'b00});
    for (int i = 0; i < tbl.size(); i++)
      run_check(0, $sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
                tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_code);

    // LATENCY=3 with req_valid held high; field changes during WAIT must not leak in.
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2;
    req_addr[1] = 32'h10; req_wdata[1] = 32'hA5A50001;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_addr[1] = 32'h20;
        req_wdata[1] = 32'h5A5A0002;
      end
      chk($sformatf("lat_ready_k%0d", k), 32'(req_ready[1]), 32'(k == 5));
      chk($sformatf("lat_valid_k%0d", k), 32'(resp_valid[1]), 32'(k == 4));
    end
    req_valid[1] = 1'b0;
    t = 0;
    while (!resp_valid[1] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("lat_second_resp", t, 3);
    @(negedge clk);
    run_check(1, "lat_ld10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hA5A50001, 2'b00);
    run_check(1, "lat_ld20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h5A5A0002, 2'b00);

    // Reset lands on the commit edge of a LATENCY=4 store.
    run_check(2, "mid_pre", 1'b1, 2'd2, 1'b0, 32'h40, 32'h01234567, 32'h0, 2'b00);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'd2;
    req_addr[2] = 32'h40; req_wdata[2] = 32'hDEADBEEF;
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    reset[2] = 1'b1;
    #1 chk("mid_ready_in_reset", 32'(req_ready[2]), 32'd0);
    @(negedge clk);
    reset[2] = 1'b0;
    #1 chk("mid_ready_after", 32'(req_ready[2]), 32'd1);
    chk("mid_valid_after", 32'(resp_valid[2]), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid[2]) seen = 1'b1;
    end
    chk("mid_no_resp", 32'(seen), 32'd0);
    run_check(2, "mid_ld40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h01234567, 2'b00);

    run_check(2, "ua_sw41", 1'b1, 2'd2, 1'b0, 32'h41, 32'hA1B2C3D4, 32'h0, 2'b00);
    run_check(2, "ua_lbu41", 1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 32'h000000A1, 2'b00);
    run_check(2, "ua_lbu44", 1'b0, 2'd0, 1'b1, 32'h44, 32'h0, 32'h000000D4, 2'b00);
    run_check(2, "ua_lw41", 1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'hA1B2C3D4, 2'b00);
    run_check(2, "ua_lh43", 1'b0, 2'd1, 1'b0, 32'h43, 32'h0, 32'hFFFFC3D4, 2'b00);
    run_check(2, "ua_lw7fe", 1'b0, 2'd2, 1'b0, 32'h7FE, 32'h0, 32'h0, 2'b10);

    random_phase(0, 200);
    random_phase(2, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
